// File: rtl/hazard_pkg.sv
// -----------------------------------------------------------------------------
// hazard_pkg
// Shared definitions for the decode-stage hazard scoreboard.
//   FWD_*        : forwarding-select encoding driven to the operand muxes
//   REG_ZERO     : architectural zero register (never tracked, never forwarded)
//   sbEntry_t    : one in-flight pipeline entry {valid, dest, isLoad}
//   destHit()    : true when an entry will write the given nonzero register
// Entries are sized by SB_ADDR_W; the top-level REG_ADDR_W must equal it.
// -----------------------------------------------------------------------------
package hazard_pkg;

  localparam int SB_ADDR_W = 5;

  localparam logic [1:0] FWD_REGFILE = 2'd0;
  localparam logic [1:0] FWD_EX      = 2'd1;
  localparam logic [1:0] FWD_MEM     = 2'd2;
  localparam logic [1:0] FWD_WB      = 2'd3;

  localparam logic [SB_ADDR_W-1:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic                 valid;
    logic [SB_ADDR_W-1:0] dest;
    logic                 isLoad;
  } sbEntry_t;

  localparam sbEntry_t ENTRY_EMPTY = '{valid: 1'b0, dest: 5'd0, isLoad: 1'b0};

  // An entry produces a value for addr only if it is live and addr is not $0.
  function automatic logic destHit(input sbEntry_t entry,
                                   input logic [SB_ADDR_W-1:0] addr);
    return entry.valid && (entry.dest == addr) && (addr != REG_ZERO);
  endfunction

endpackage

// File: rtl/hazard_forward_select.sv
// -----------------------------------------------------------------------------
// hazard_forward_select
// Combinational priority comparator choosing the bypass source for one operand.
// Ports:
//   opUsed   in  1          operand is actually read by the ID instruction
//   opAddr   in  SB_ADDR_W  operand register address
//   exEntry  in  sbEntry_t  instruction currently in EX
//   memEntry in  sbEntry_t  instruction currently in MEM
//   wbEntry  in  sbEntry_t  instruction currently in WB
//   fwdSel   out 2          FWD_REGFILE / FWD_EX / FWD_MEM / FWD_WB
// -----------------------------------------------------------------------------
module hazard_forward_select
  import hazard_pkg::*;
(
  input  logic                 opUsed,
  input  logic [SB_ADDR_W-1:0] opAddr,
  input  sbEntry_t             exEntry,
  input  sbEntry_t             memEntry,
  input  sbEntry_t             wbEntry,
  output logic [1:0]           fwdSel
);

  // Youngest producer wins. A load in EX has no ALU result yet, so it is
  // skipped here; the load-use stall keeps the consumer in ID for that cycle.
  always_comb begin
    fwdSel = FWD_REGFILE;
    if (!opUsed || (opAddr == REG_ZERO)) begin
      fwdSel = FWD_REGFILE;
    end else if (destHit(exEntry, opAddr) && !exEntry.isLoad) begin
      fwdSel = FWD_EX;
    end else if (destHit(memEntry, opAddr)) begin
      fwdSel = FWD_MEM;
    end else if (destHit(wbEntry, opAddr)) begin
      fwdSel = FWD_WB;
    end else begin
      fwdSel = FWD_REGFILE;
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// -----------------------------------------------------------------------------
// hazard_scoreboard
// Decode-stage hazard controller: tracks destinations of instructions in
// EX/MEM/WB, raises the ID stall on load-use hazards, freezes the pipeline
// while data memory is busy, inserts bubbles, and selects operand bypasses.
// Optional feature: define HAZARD_SCOREBOARD_STATS_EN to build saturating
// stall/freeze cycle counters; otherwise the counter ports are tied to 0.
// Ports:
//   clock, reset (async, active-low)
//   idValid, idRs, idRt, idUsesRs, idUsesRt, idWritesRegister, idDest,
//   idIsLoad                : decode-stage instruction description
//   flush                   : kill the ID instruction (taken branch/jump)
//   memReady                : data memory done; 0 freezes the pipeline
//   shouldStall             : hold PC and IF/ID
//   shouldFreeze            : hold ID/EX, EX/MEM, MEM/WB
//   forwardRs, forwardRt    : bypass selects (see hazard_pkg FWD_*)
//   stallCycles, freezeCycles : statistics counters
// -----------------------------------------------------------------------------
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W = 5,
  parameter int STAT_W     = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  idValid,
  input  logic [REG_ADDR_W-1:0] idRs,
  input  logic [REG_ADDR_W-1:0] idRt,
  input  logic                  idUsesRs,
  input  logic                  idUsesRt,
  input  logic                  idWritesRegister,
  input  logic [REG_ADDR_W-1:0] idDest,
  input  logic                  idIsLoad,
  input  logic                  flush,
  input  logic                  memReady,
  output logic                  shouldStall,
  output logic                  shouldFreeze,
  output logic [1:0]            forwardRs,
  output logic [1:0]            forwardRt,
  output logic [STAT_W-1:0]     stallCycles,
  output logic [STAT_W-1:0]     freezeCycles
);

  sbEntry_t exEntry;
  sbEntry_t memEntry;
  sbEntry_t wbEntry;
  sbEntry_t exNext;
  logic     freeze;
  logic     loadUse;

  // Outputs must read 0 while reset is held, even if memReady is low.
  assign freeze       = reset && !memReady;
  assign shouldFreeze = freeze;
  assign shouldStall  = freeze || (loadUse && !flush);

  // Consumer in ID needs a value a load in EX has not produced yet.
  always_comb begin
    loadUse = 1'b0;
    if (idValid && exEntry.valid && exEntry.isLoad && (exEntry.dest != REG_ZERO)) begin
      loadUse = (idUsesRs && (idRs == exEntry.dest)) ||
                (idUsesRt && (idRt == exEntry.dest));
    end else begin
      loadUse = 1'b0;
    end
  end

  // Next EX entry: only real, nonzero-destination writers that are neither
  // flushed nor stalled enter the scoreboard; everything else is a bubble.
  // Flush takes precedence over a load-use stall.
  always_comb begin
    exNext = ENTRY_EMPTY;
    if (idValid && idWritesRegister && (idDest != REG_ZERO) && !flush && !loadUse) begin
      exNext = '{valid: 1'b1, dest: idDest, isLoad: idIsLoad};
    end else begin
      exNext = ENTRY_EMPTY;
    end
  end

  // Pipeline shadow: advances on every unfrozen edge, holds while frozen.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      exEntry  <= ENTRY_EMPTY;
      memEntry <= ENTRY_EMPTY;
      wbEntry  <= ENTRY_EMPTY;
    end else if (!freeze) begin
      exEntry  <= exNext;
      memEntry <= exEntry;
      wbEntry  <= memEntry;
    end else begin
      exEntry  <= exEntry;
      memEntry <= memEntry;
      wbEntry  <= wbEntry;
    end
  end

  hazard_forward_select uFwdRs (
    .opUsed   (idUsesRs),
    .opAddr   (idRs),
    .exEntry  (exEntry),
    .memEntry (memEntry),
    .wbEntry  (wbEntry),
    .fwdSel   (forwardRs)
  );

  hazard_forward_select uFwdRt (
    .opUsed   (idUsesRt),
    .opAddr   (idRt),
    .exEntry  (exEntry),
    .memEntry (memEntry),
    .wbEntry  (wbEntry),
    .fwdSel   (forwardRt)
  );

`ifdef HAZARD_SCOREBOARD_STATS_EN
  localparam logic [STAT_W-1:0] STAT_ZERO = {STAT_W{1'b0}};
  localparam logic [STAT_W-1:0] STAT_ONE  = {{(STAT_W-1){1'b0}}, 1'b1};
  localparam logic [STAT_W-1:0] STAT_MAX  = {STAT_W{1'b1}};

  logic [STAT_W-1:0] stallCount;
  logic [STAT_W-1:0] freezeCount;

  // Saturating counters; a flushed load-use is not a stall, and frozen
  // cycles count only as freeze.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stallCount  <= STAT_ZERO;
      freezeCount <= STAT_ZERO;
    end else begin
      if (loadUse && !flush && !freeze && (stallCount != STAT_MAX)) begin
        stallCount <= stallCount + STAT_ONE;
      end else begin
        stallCount <= stallCount;
      end
      if (freeze && (freezeCount != STAT_MAX)) begin
        freezeCount <= freezeCount + STAT_ONE;
      end else begin
        freezeCount <= freezeCount;
      end
    end
  end

  assign stallCycles  = stallCount;
  assign freezeCycles = freezeCount;
`else
  assign stallCycles  = {STAT_W{1'b0}};
  assign freezeCycles = {STAT_W{1'b0}};
`endif

endmodule
